// File: rtl/fetch_pkg.sv
//------------------------------------------------------------------------------
// Module   : fetch_pkg
// Purpose  : Shared state encoding and default widths for the fetch sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int c_ADDR_WIDTH  = 12;
  localparam int c_INSTR_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    HOLD   = 3'd3,
    HALTED = 3'd4
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : fetch_ctrl_if
// Purpose  : Instruction-memory read bus plus decode valid/ready handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_ctrl_if
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = c_ADDR_WIDTH,
  parameter int INSTR_WIDTH = c_INSTR_WIDTH
);

  logic                   memRdEn;
  logic [ADDR_WIDTH-1:0]  memAddr;
  logic [INSTR_WIDTH-1:0] memRdata;
  logic                   memValid;
  logic                   instrValid;
  logic                   instrReady;
  logic [INSTR_WIDTH-1:0] instrOut;

  modport master (
    output memRdEn, memAddr, instrValid, instrOut,
    input  memRdata, memValid, instrReady
  );

  modport slave (
    input  memRdEn, memAddr, instrValid, instrOut,
    output memRdata, memValid, instrReady
  );

endinterface

`default_nettype wire

// File: rtl/fetch_ctrl_inc_register.sv
//------------------------------------------------------------------------------
// Module   : incRegister
// Purpose  : Loadable, incrementing register; a load takes priority over increment.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module incRegister #(
  parameter int               WIDTH     = 12,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             rstN,
  input  wire logic             wrEn,
  input  wire logic             incEn,
  input  wire logic [WIDTH-1:0] dataIn,
  output logic      [WIDTH-1:0] dataOut
);

  logic [WIDTH-1:0] r_val;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_val <= RESET_VAL;
    end else if (wrEn) begin
      r_val <= dataIn;
    end else if (incEn) begin
      r_val <= r_val + WIDTH'(1);
    end
  end

  assign dataOut = r_val;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : fetch_ctrl
// Purpose  : Instruction-fetch sequencer with jump redirect and halt.
//            Optional FETCH_COUNT_EN adds a fetchCount handshake counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = c_ADDR_WIDTH,
  parameter int                    INSTR_WIDTH = c_INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0
) (
  input  wire logic                  clk,
  input  wire logic                  rstN,
  input  wire logic                  start,
  input  wire logic                  halt,
  input  wire logic                  jmpEn,
  input  wire logic [ADDR_WIDTH-1:0] jmpAddr,
  fetch_ctrl_if.master               bus,
  output logic      [ADDR_WIDTH-1:0] pcOut,
  output logic                       busy,
  output logic                       done
`ifdef FETCH_COUNT_EN
  ,
  output logic      [31:0]           fetchCount
`endif
);

  fetch_state_t           r_state, w_stateNext;
  logic                   r_flush, w_flushNext;
  logic                   r_haltPend, w_haltPendNext;
  logic                   r_instrValid, w_instrValidNext;
  logic [INSTR_WIDTH-1:0] r_instrOut;
  logic                   w_capture;
  logic                   w_pcWr, w_pcInc;
  logic [ADDR_WIDTH-1:0]  w_pcDin, w_pc;

  incRegister #(
    .WIDTH     (ADDR_WIDTH),
    .RESET_VAL (START_ADDR)
  ) u_pc (
    .clk     (clk),
    .rstN    (rstN),
    .wrEn    (w_pcWr),
    .incEn   (w_pcInc),
    .dataIn  (w_pcDin),
    .dataOut (w_pc)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext      = r_state;
    w_flushNext      = r_flush;
    w_haltPendNext   = r_haltPend;
    w_instrValidNext = r_instrValid;
    w_capture        = 1'b0;
    w_pcWr           = 1'b0;
    w_pcInc          = 1'b0;
    w_pcDin          = jmpAddr;
    case (r_state)
      IDLE: begin
        w_flushNext    = 1'b0;
        w_haltPendNext = 1'b0;
        if (start) begin
          w_pcWr      = 1'b1;
          w_pcDin     = START_ADDR;
          w_stateNext = REQ;
        end
      end
      REQ: begin
        w_stateNext = WAIT;
        if (jmpEn) begin
          w_pcWr      = 1'b1;
          w_flushNext = 1'b1;
        end
        if (halt) w_haltPendNext = 1'b1;
      end
      WAIT: begin
        if (bus.memValid) begin
          // A same-cycle jump also invalidates the returning read.
          w_pcWr = jmpEn;
          if (r_haltPend || halt) begin
            w_stateNext    = HALTED;
            w_flushNext    = 1'b0;
            w_haltPendNext = 1'b0;
          end else if (r_flush || jmpEn) begin
            w_stateNext = REQ;
            w_flushNext = 1'b0;
          end else begin
            w_capture        = 1'b1;
            w_instrValidNext = 1'b1;
            w_pcInc          = 1'b1;
            w_stateNext      = HOLD;
          end
        end else begin
          if (jmpEn) begin
            w_pcWr      = 1'b1;
            w_flushNext = 1'b1;
          end
          if (halt) w_haltPendNext = 1'b1;
        end
      end
      HOLD: begin
        if (jmpEn) begin
          w_pcWr           = 1'b1;
          w_instrValidNext = 1'b0;
          w_haltPendNext   = 1'b0;
          w_stateNext      = (halt || r_haltPend) ? HALTED : REQ;
        end else if (halt || r_haltPend) begin
          w_instrValidNext = 1'b0;
          w_haltPendNext   = 1'b0;
          w_stateNext      = HALTED;
        end else if (bus.instrReady) begin
          w_instrValidNext = 1'b0;
          w_stateNext      = REQ;
        end
      end
      HALTED: begin
        w_flushNext    = 1'b0;
        w_haltPendNext = 1'b0;
        if (start) w_stateNext = REQ;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_flush      <= 1'b0;
      r_haltPend   <= 1'b0;
      r_instrValid <= 1'b0;
      r_instrOut   <= '0;
    end else begin
      r_flush      <= w_flushNext;
      r_haltPend   <= w_haltPendNext;
      r_instrValid <= w_instrValidNext;
      if (w_capture) r_instrOut <= bus.memRdata;
    end
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] r_fetchCount;
  logic        w_handshake;
  logic        w_clrCount;

  // A jump in HOLD drops the instruction, so it is not counted.
  assign w_handshake = (r_state == HOLD) && r_instrValid && bus.instrReady && !jmpEn;
  assign w_clrCount  = (r_state == IDLE) && start;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_fetchCount <= '0;
    end else if (w_clrCount) begin
      r_fetchCount <= '0;
    end else if (w_handshake) begin
      r_fetchCount <= r_fetchCount + 32'd1;
    end
  end

  assign fetchCount = r_fetchCount;
`endif

  assign bus.memRdEn    = (r_state == REQ);
  assign bus.memAddr    = w_pc;
  assign bus.instrValid = r_instrValid;
  assign bus.instrOut   = r_instrOut;
  assign pcOut          = w_pc;
  assign busy           = (r_state == REQ) || (r_state == WAIT) || (r_state == HOLD);
  assign done           = (r_state == HALTED);

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_ctrl
// Purpose  : Self-checking bench for fetch_ctrl: vector table plus corner sequences.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        jmpEn = 1'b0;
  logic [11:0] jmpAddr = '0;
  logic [11:0] pcOut;
  logic        busy;
  logic        done;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetchCount;
`endif

  int nChecks = 0;
  int nFail   = 0;

  fetch_ctrl_if #(.ADDR_WIDTH(12), .INSTR_WIDTH(8)) bus ();

  fetch_ctrl #(.ADDR_WIDTH(12), .INSTR_WIDTH(8), .START_ADDR(12'h000)) dut (
    .clk     (clk),
    .rstN    (rstN),
    .start   (start),
    .halt    (halt),
    .jmpEn   (jmpEn),
    .jmpAddr (jmpAddr),
    .bus     (bus.master),
    .pcOut   (pcOut),
    .busy    (busy),
    .done    (done)
`ifdef FETCH_COUNT_EN
    ,
    .fetchCount (fetchCount)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a function of address.
  function automatic logic [7:0] memf(input logic [11:0] a);
    return (a[7:0] * 8'd7) + {4'h0, a[11:8]} + 8'h3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetAndStart();
    rstN = 1'b0;
    start = 1'b0; halt = 1'b0; jmpEn = 1'b0; jmpAddr = '0;
    bus.memValid = 1'b0; bus.memRdata = '0; bus.instrReady = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    check("rst_memRdEn", bus.memRdEn, 0);
    check("rst_instrValid", bus.instrValid, 0);
    check("rst_instrOut", bus.instrOut, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pc", pcOut, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_rdEn_latency", bus.memRdEn, 1);
  endtask

  task automatic fetchOne(input logic [11:0] expAddr, input int lat, input int rdy,
                          input logic [7:0] expInstr, input logic [11:0] expPc);
    logic [11:0] a;
    int n;
    n = 0;
    while (!bus.memRdEn && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rdEn_seen", bus.memRdEn, 1);
    a = bus.memAddr;
    check("memAddr", a, expAddr);
    @(negedge clk);
    check("rdEn_pulse", bus.memRdEn, 0);
    repeat (lat - 1) @(negedge clk);
    bus.memValid = 1'b1;
    bus.memRdata = memf(a);
    @(negedge clk);
    bus.memValid = 1'b0;
    bus.memRdata = '0;
    check("instrValid", bus.instrValid, 1);
    check("instrOut", bus.instrOut, expInstr);
    check("pc_hold", pcOut, expPc);
    repeat (rdy) begin
      @(negedge clk);
      check("hold_valid", bus.instrValid, 1);
      check("hold_instr", bus.instrOut, expInstr);
      check("hold_noRd", bus.memRdEn, 0);
      check("hold_pc", pcOut, expPc);
    end
    bus.instrReady = 1'b1;
    @(negedge clk);
    bus.instrReady = 1'b0;
    check("handshake_clr", bus.instrValid, 0);
  endtask

  typedef struct {
    bit          doStart;
    int          lat;
    int          rdy;
    logic [11:0] addr;
    logic [7:0]  instr;
    logic [11:0] pcAfter;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b1, 1, 0, 12'h000, memf(12'h000), 12'h001};
    vecs[1] = '{1'b0, 1, 0, 12'h001, memf(12'h001), 12'h002};
    vecs[2] = '{1'b0, 1, 0, 12'h002, memf(12'h002), 12'h003};
    vecs[3] = '{1'b0, 3, 2, 12'h003, memf(12'h003), 12'h004};
    vecs[4] = '{1'b1, 1, 5, 12'h000, memf(12'h000), 12'h001};

    foreach (vecs[i]) begin
      if (vecs[i].doStart) resetAndStart();
      fetchOne(vecs[i].addr, vecs[i].lat, vecs[i].rdy, vecs[i].instr, vecs[i].pcAfter);
    end

    // Jump while waiting: in-flight data discarded, refetch from target.
    check("j1_rdEn", bus.memRdEn, 1);
    check("j1_addr", bus.memAddr, 12'h001);
    @(negedge clk);
    jmpEn = 1'b1; jmpAddr = 12'h3F0;
    @(negedge clk);
    jmpEn = 1'b0;
    check("j1_pc", pcOut, 12'h3F0);
    bus.memValid = 1'b1; bus.memRdata = memf(12'h001);
    @(negedge clk);
    bus.memValid = 1'b0;
    check("j1_discard", bus.instrValid, 0);
    check("j1_reRd", bus.memRdEn, 1);
    check("j1_reAddr", bus.memAddr, 12'h3F0);
    fetchOne(12'h3F0, 1, 0, memf(12'h3F0), 12'h3F1);

    // Jump in REQ to the top address; PC wraps after fetching it.
    check("j2_rdEn", bus.memRdEn, 1);
    jmpEn = 1'b1; jmpAddr = 12'hFFF;
    @(negedge clk);
    jmpEn = 1'b0;
    check("j2_pc", pcOut, 12'hFFF);
    bus.memValid = 1'b1; bus.memRdata = memf(12'h3F1);
    @(negedge clk);
    bus.memValid = 1'b0;
    check("j2_discard", bus.instrValid, 0);
    fetchOne(12'hFFF, 1, 0, memf(12'hFFF), 12'h000);
    fetchOne(12'h000, 2, 1, memf(12'h000), 12'h001);

    // Halt in WAIT with late memory response.
    check("h_addr", bus.memAddr, 12'h001);
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    repeat (3) begin
      check("h_notDone", done, 0);
      check("h_busy", busy, 1);
      @(negedge clk);
    end
    bus.memValid = 1'b1; bus.memRdata = memf(12'h001);
    @(negedge clk);
    bus.memValid = 1'b0;
    check("h_done", done, 1);
    check("h_busyLow", busy, 0);
    check("h_noValid", bus.instrValid, 0);
    check("h_pc", pcOut, 12'h001);
    repeat (3) begin
      @(negedge clk);
      check("h_idleRd", bus.memRdEn, 0);
      check("h_stayDone", done, 1);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("h_resumeRd", bus.memRdEn, 1);
    check("h_resumeAddr", bus.memAddr, 12'h001);
    check("h_resumeDone", done, 0);
    fetchOne(12'h001, 1, 0, memf(12'h001), 12'h002);

    // Asynchronous reset mid-WAIT; late memValid must be ignored.
    @(negedge clk);
    check("r_busyPre", busy, 1);
    rstN = 1'b0;
    #1;
    check("r_rdEn", bus.memRdEn, 0);
    check("r_valid", bus.instrValid, 0);
    check("r_instr", bus.instrOut, 0);
    check("r_busy", busy, 0);
    check("r_done", done, 0);
    check("r_pc", pcOut, 0);
    @(negedge clk);
    rstN = 1'b1;
    bus.memValid = 1'b1; bus.memRdata = memf(12'h002);
    @(negedge clk);
    bus.memValid = 1'b0;
    repeat (2) begin
      check("r_ignValid", bus.instrValid, 0);
      check("r_ignInstr", bus.instrOut, 0);
      check("r_ignBusy", busy, 0);
      check("r_ignRd", bus.memRdEn, 0);
      check("r_ignPc", pcOut, 0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
